screen_scanner: RTL and testbench



---
 rtl/screen_scanner.sv | 152 +++++++++++++++
 tb/tb_screen_scanner.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/screen_scanner.sv
// screen_scanner: walks the Hack screen map in raster order and serialises each
// 16-bit word LSB-first into a 1-bit pixel stream with valid/ready handshake.
// Optional build macro SCREEN_SCANNER_PREFETCH_EN adds a one-word holding
// register so the next word is read during SHIFT and the stream never bubbles.
module screen_scanner #(
  parameter int ROWS          = 256,
  parameter int WORDS_PER_ROW = 32,
  parameter int AW            = 13
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          enable,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [15:0]   mem_rdata,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic          pix_data,
  output logic          pix_sof,
  output logic          pix_eol,
  output logic          busy
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, SHIFT} state_t;

  state_t        state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [3:0]    bit_cnt;
  logic [15:0]   shreg;

`ifdef SCREEN_SCANNER_PREFETCH_EN
  logic [15:0]   hold;
  logic          hold_vld;
  logic          rd_pend;
`endif

  logic          xfer;
  logic          last_col;
  logic          last_row;
  logic          last_word;
  logic [RW-1:0] next_row;
  logic [CW-1:0] next_col;
  logic [AW-1:0] cur_addr;
  logic [AW-1:0] next_addr;

  // Counter decodes and the address of the current and following word.
  assign xfer      = pix_valid & pix_ready;
  assign last_col  = (col == CW'(WORDS_PER_ROW - 1));
  assign last_row  = (row == RW'(ROWS - 1));
  assign last_word = last_col & last_row;
  assign next_col  = last_col ? '0 : col + CW'(1);
  assign next_row  = last_col ? (last_row ? '0 : row + RW'(1)) : row;
  assign cur_addr  = AW'(int'(row) * WORDS_PER_ROW + int'(col));
  assign next_addr = AW'(int'(next_row) * WORDS_PER_ROW + int'(next_col));

  // Pixel value and frame/line markers, all qualified by pix_valid.
  assign pix_data = pix_valid & shreg[bit_cnt];
  assign pix_sof  = pix_valid & (row == '0) & (col == '0) & (bit_cnt == 4'd0);
  assign pix_eol  = pix_valid & last_col & (bit_cnt == 4'd15);

  // Fetch/shift sequencer with registered read strobe, valid and busy.
  // NOTE: all state here uses nonblocking assignments so every register samples
  // pre-edge values; blocking assignments would make ordering matter.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      pix_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef SCREEN_SCANNER_PREFETCH_EN
      hold      <= '0;
      hold_vld  <= 1'b0;
      rd_pend   <= 1'b0;
`endif
    end else begin
      // NOTE: the read strobe defaults low each cycle so it is a one-cycle pulse
      // wherever a branch below does not explicitly raise it.
      mem_rd_en <= 1'b0;
`ifdef SCREEN_SCANNER_PREFETCH_EN
      // A prefetch issued in SHIFT returns one cycle later into the holding reg.
      rd_pend <= mem_rd_en && (state == SHIFT);
      if (rd_pend) begin
        hold     <= mem_rdata;
        hold_vld <= 1'b1;
      end
`endif
      case (state)
        IDLE: begin
          if (enable) begin
            busy      <= 1'b1;
            mem_rd_en <= 1'b1;
            mem_addr  <= cur_addr;
            state     <= FETCH;
          end
        end
        FETCH: begin
          state <= LOAD;
        end
        LOAD: begin
          shreg     <= mem_rdata;
          bit_cnt   <= '0;
          pix_valid <= 1'b1;
          state     <= SHIFT;
        end
        SHIFT: begin
          if (xfer) begin
            bit_cnt <= bit_cnt + 4'd1;
`ifdef SCREEN_SCANNER_PREFETCH_EN
            // Request the next word as the stream moves on to bit 13.
            if (bit_cnt == 4'd12 && !last_word) begin
              mem_rd_en <= 1'b1;
              mem_addr  <= next_addr;
            end
`endif
            if (bit_cnt == 4'd15) begin
              col <= next_col;
              row <= next_row;
              if (last_word) begin
                pix_valid <= 1'b0;
                busy      <= 1'b0;
                state     <= IDLE;
              end
`ifdef SCREEN_SCANNER_PREFETCH_EN
              else if (hold_vld) begin
                shreg    <= hold;
                hold_vld <= 1'b0;
              end
`endif
              else begin
                pix_valid <= 1'b0;
                mem_rd_en <= 1'b1;
                mem_addr  <= next_addr;
                state     <= FETCH;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_screen_scanner.sv
// tb_screen_scanner: randomized self-checking bench for screen_scanner on a
// reduced 8x32-word screen. The reference model is the raster-ordered pixel
// list derived from the RAM image: pixel k is bit k%16 of word k/16.
module tb_screen_scanner;

  localparam int ROWS = 8;
  localparam int WPR  = 32;
  localparam int AW   = 8;
  localparam int NW   = ROWS * WPR;
  localparam int NPIX = NW * 16;
`ifdef SCREEN_SCANNER_PREFETCH_EN
  localparam int GAP  = 0;
`else
  localparam int GAP  = 2;
`endif

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          enable = 1'b0;
  logic          pix_ready = 1'b0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_rdata = '0;
  logic          pix_valid;
  logic          pix_data;
  logic          pix_sof;
  logic          pix_eol;
  logic          busy;

  logic [15:0]   ram [NW];

  int n_vec = 0;
  int n_err = 0;
  int ready_mode = 0;

  // Scoreboard state, owned by the monitor process.
  int   pix_idx = 0;
  int   rd_idx = 0;
  int   rd_in_frame = 0;
  int   frames_done = 0;
  int   gap_cnt = 0;
  bit   in_gap = 0;
  bit   after_last = 0;
  bit   prev_stall = 0;
  logic prev_data, prev_sof, prev_eol;
  logic [15:0] mword;
  int   mw, mb;

  always #5 CLK = ~CLK;

  screen_scanner #(.ROWS(ROWS), .WORDS_PER_ROW(WPR), .AW(AW)) dut (
    .CLK(CLK), .RST_N(RST_N), .enable(enable),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .busy(busy)
  );

  // Screen RAM: data valid exactly one cycle after the read strobe.
  always @(posedge CLK) begin
    if (mem_rd_en) mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, between active edges.
  always @(negedge CLK) begin
    if (!RST_N) begin
      pix_idx = 0; rd_idx = 0; rd_in_frame = 0;
      prev_stall = 0; after_last = 0; in_gap = 0; gap_cnt = 0;
    end else begin
      if (after_last) begin
        check("busy_fall", 32'(busy), 32'(0));
        after_last = 0;
      end
      if (mem_rd_en) begin
        check("rd_addr", 32'(mem_addr), 32'(rd_idx));
        rd_idx = (rd_idx + 1) % NW;
        rd_in_frame++;
      end
      if (prev_stall) begin
        check("stall_valid", 32'(pix_valid), 32'(1));
        check("stall_data", 32'(pix_data), 32'(prev_data));
        check("stall_sof", 32'(pix_sof), 32'(prev_sof));
        check("stall_eol", 32'(pix_eol), 32'(prev_eol));
      end
      if (in_gap) begin
        if (pix_valid) begin
          check("word_gap", 32'(gap_cnt), 32'(GAP));
          in_gap = 0;
        end else begin
          gap_cnt++;
        end
      end
      if (pix_valid && pix_ready) begin
        mw = pix_idx / 16;
        mb = pix_idx % 16;
        mword = ram[mw];
        check("pix_data", 32'(pix_data), 32'(mword[mb]));
        check("pix_sof", 32'(pix_sof), 32'(pix_idx == 0));
        check("pix_eol", 32'(pix_eol), 32'((mw % WPR == WPR - 1) && (mb == 15)));
        check("busy_frame", 32'(busy), 32'(1));
        if (pix_idx == NPIX - 1) begin
          check("rd_count", 32'(rd_in_frame), 32'(NW));
          rd_in_frame = 0;
          after_last = 1;
          frames_done++;
          pix_idx = 0;
        end else begin
          pix_idx++;
          if (mb == 15) begin
            in_gap = 1;
            gap_cnt = 0;
          end
        end
      end
      prev_stall = pix_valid && !pix_ready;
      prev_data  = pix_data;
      prev_sof   = pix_sof;
      prev_eol   = pix_eol;
    end
  end

  // One clock step; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
    case (ready_mode)
      0:       pix_ready = 1'b1;
      1:       pix_ready = ($urandom_range(0, 3) != 0);
      default: ;
    endcase
  endtask

  task automatic wait_frames(input int target, input int budget);
    int c = 0;
    while (frames_done < target && c < budget) begin
      tick();
      c++;
    end
    check("frame_timeout", 32'(frames_done >= target), 32'(1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, 32'(mem_rd_en), 32'(0));
    check({tag, "_addr"},  32'(mem_addr),  32'(0));
    check({tag, "_valid"}, 32'(pix_valid), 32'(0));
    check({tag, "_data"},  32'(pix_data),  32'(0));
    check({tag, "_sof"},   32'(pix_sof),   32'(0));
    check({tag, "_eol"},   32'(pix_eol),   32'(0));
    check({tag, "_busy"},  32'(busy),      32'(0));
  endtask

  initial begin
    int lat;
    int cyc;
    int guard;

    for (int i = 0; i < NW; i++) ram[i] = 16'($urandom);
    ram[0] = 16'hA5F0;

    // Reset state.
    RST_N = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    RST_N = 1'b1;
    tick();
    check("idle_busy", 32'(busy), 32'(0));

    // Frame 1: start latency, first word A5F0, then random backpressure.
    enable = 1'b1;
    lat = 0;
    while (!pix_valid && lat < 10) begin
      tick();
      lat++;
    end
    check("start_latency", 32'(lat), 32'(3));
    check("start_busy", 32'(busy), 32'(1));
    check("first_pix_data", 32'(pix_data), 32'(0));
    check("first_pix_sof", 32'(pix_sof), 32'(1));
    enable = 1'b0;
    ready_mode = 1;
    wait_frames(1, 20000);

    // Frame 2: stall 7 cycles on bit 4 of word 0x0010; enable stays high.
    ram[0] = 16'h0010;
    ready_mode = 0;
    enable = 1'b1;
    guard = 0;
    while (!(pix_valid && pix_idx == 4) && guard < 50) begin
      tick();
      guard++;
    end
    check("bp_reach_bit4", 32'(pix_idx), 32'(4));
    ready_mode = 2;
    pix_ready = 1'b0;
    repeat (7) begin
      tick();
      check("bp_valid", 32'(pix_valid), 32'(1));
      check("bp_data", 32'(pix_data), 32'(1));
    end
    check("bp_no_skip", 32'(pix_idx), 32'(4));
    ready_mode = 1;
    wait_frames(2, 20000);

    // Enable held high: frame 3 starts from address 0 right after IDLE.
    check("end_busy_low", 32'(busy), 32'(0));
    tick();
    check("restart_rd", 32'(mem_rd_en), 32'(1));
    check("restart_addr", 32'(mem_addr), 32'(0));
    check("restart_busy", 32'(busy), 32'(1));
    enable = 1'b0;
    guard = 0;
    while (!pix_valid && guard < 10) begin
      tick();
      guard++;
    end
    check("restart_sof", 32'(pix_sof), 32'(1));

    // Frame 3 aborted by reset in SHIFT at row 5, col 3.
    guard = 0;
    while (!(pix_valid && pix_idx >= (5 * WPR + 3) * 16 + 2) && guard < 20000) begin
      tick();
      guard++;
    end
    check("mid_reached", 32'(pix_idx / 16), 32'(5 * WPR + 3));
    RST_N = 1'b0;
    tick();
    check_all_zero("midreset");

    // Frame 4: full-rate frame from address 0; total pixel-phase cycles.
    for (int i = 0; i < NW; i++) ram[i] = 16'($urandom);
    ready_mode = 0;
    RST_N = 1'b1;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    check("post_reset_addr", 32'(mem_addr), 32'(0));
    guard = 0;
    while (!pix_valid && guard < 10) begin
      tick();
      guard++;
    end
    cyc = 0;
    while (frames_done < 3 && cyc < 20000) begin
      tick();
      cyc++;
    end
    check("frame_cycles", 32'(cyc), 32'(NPIX + GAP * (NW - 1)));
    repeat (3) tick();
    check("final_idle_busy", 32'(busy), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
